// File: rtl/fetch_sequencer.sv
// PC sequencer: merges boot, memory-wait, load-use, ID/EX redirect and optional trap
// sources into PC hold/redirect controls plus flush strobes. Trap path: FETCH_TRAP_REDIRECT_EN.
module fetch_sequencer #(
    parameter int          BOOT_CYCLES  = 2,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemReady,
    input  logic        loadUseHazard,
    input  logic        idRedirect,
    input  logic [31:0] idTarget,
    input  logic        exRedirect,
    input  logic [31:0] exTarget,
    input  logic        trapReq,
    output logic        isStalled,
    output logic        shouldGoToTarget,
    output logic [31:0] jumpTarget,
    output logic        flushIfId,
    output logic        flushIdEx
);

    localparam int CNT_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
`ifdef FETCH_TRAP_REDIRECT_EN
        , DRAIN = 2'd3
`endif
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [31:0]        pending, pending_next;

`ifndef FETCH_TRAP_REDIRECT_EN
    logic unused_trap;
    assign unused_trap = trapReq ^ (^TRAP_VECTOR);
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= BOOT;
            cnt     <= CNT_W'(BOOT_CYCLES - 1);
            pending <= 32'h0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pending <= pending_next;
        end
    end

    // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        pending_next     = pending;
        isStalled        = 1'b0;
        shouldGoToTarget = 1'b0;
        jumpTarget       = 32'h0;
        flushIfId        = 1'b0;
        flushIdEx        = 1'b0;

        case (state)
            BOOT: begin
                isStalled = 1'b1;
                flushIfId = 1'b1;
                flushIdEx = 1'b1;
                if (cnt == '0) state_next = RUN;
                else           cnt_next   = cnt - CNT_W'(1);
            end

            RUN: begin
`ifdef FETCH_TRAP_REDIRECT_EN
                if (trapReq) begin
                    isStalled  = 1'b1;
                    flushIfId  = 1'b1;
                    flushIdEx  = 1'b1;
                    cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
                    state_next = DRAIN;
                end else
`endif
                if (exRedirect || idRedirect) begin
                    // EX outranks ID; only an EX redirect also kills the ID/EX stage.
                    flushIfId = 1'b1;
                    flushIdEx = exRedirect;
                    if (imemReady) begin
                        shouldGoToTarget = 1'b1;
                        jumpTarget       = exRedirect ? exTarget : idTarget;
                    end else begin
                        isStalled    = 1'b1;
                        pending_next = exRedirect ? exTarget : idTarget;
                        state_next   = HOLD;
                    end
                end else if (loadUseHazard) begin
                    isStalled = 1'b1;
                    flushIdEx = 1'b1;
                end else if (!imemReady) begin
                    isStalled = 1'b1;
                    flushIfId = 1'b1;
                end
            end

            HOLD: begin
                isStalled = 1'b1;
                flushIfId = 1'b1;
`ifdef FETCH_TRAP_REDIRECT_EN
                if (trapReq) begin
                    pending_next = 32'h0;
                    cnt_next     = CNT_W'(DRAIN_CYCLES - 1);
                    state_next   = DRAIN;
                end else
`endif
                if (imemReady) begin
                    shouldGoToTarget = 1'b1;
                    jumpTarget       = pending;
                    state_next       = RUN;
                end
            end

`ifdef FETCH_TRAP_REDIRECT_EN
            DRAIN: begin
                isStalled = 1'b1;
                flushIfId = 1'b1;
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (imemReady) begin
                    shouldGoToTarget = 1'b1;
                    jumpTarget       = TRAP_VECTOR;
                    state_next       = RUN;
                end else begin
                    pending_next = TRAP_VECTOR;
                    state_next   = HOLD;
                end
            end
`endif

            default: begin
                isStalled  = 1'b1;
                flushIfId  = 1'b1;
                flushIdEx  = 1'b1;
                cnt_next   = CNT_W'(BOOT_CYCLES - 1);
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-budget reference model of the sequencing rules.
module tb_fetch_sequencer;

    localparam int          BOOT  = 2;
    localparam int          DRAIN = 3;
    localparam logic [31:0] TVEC  = 32'h0000_0100;
`ifdef FETCH_TRAP_REDIRECT_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [35:0] RESET_VEC = {1'b1, 1'b0, 32'h0, 1'b1, 1'b1};

    logic        clk, rst;
    logic        imemReady, loadUseHazard, idRedirect, exRedirect, trapReq;
    logic [31:0] idTarget, exTarget;
    logic        isStalled, shouldGoToTarget, flushIfId, flushIdEx;
    logic [31:0] jumpTarget;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: remaining boot/drain cycles and an optional pending redirect.
    int          m_boot, m_drain, n_boot, n_drain;
    bit          m_hold, n_hold;
    logic [31:0] m_tgt, n_tgt;
    logic [35:0] e_vec;

    fetch_sequencer #(
        .BOOT_CYCLES (BOOT),
        .DRAIN_CYCLES(DRAIN),
        .TRAP_VECTOR (TVEC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imemReady       (imemReady),
        .loadUseHazard   (loadUseHazard),
        .idRedirect      (idRedirect),
        .idTarget        (idTarget),
        .exRedirect      (exRedirect),
        .exTarget        (exTarget),
        .trapReq         (trapReq),
        .isStalled       (isStalled),
        .shouldGoToTarget(shouldGoToTarget),
        .jumpTarget      (jumpTarget),
        .flushIfId       (flushIfId),
        .flushIdEx       (flushIdEx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [35:0] dut_vec();
        return {isStalled, shouldGoToTarget, jumpTarget, flushIfId, flushIdEx};
    endfunction

    task automatic model_reset();
        m_boot  = BOOT;
        m_drain = 0;
        m_hold  = 1'b0;
        m_tgt   = 32'h0;
    endtask

    task automatic model_eval();
        logic        st, go, fi, fe;
        logic [31:0] tg;
        st = 0; go = 0; fi = 0; fe = 0; tg = 32'h0;
        n_boot = m_boot; n_drain = m_drain; n_hold = m_hold; n_tgt = m_tgt;
        if (m_boot > 0) begin
            st = 1; fi = 1; fe = 1;
            n_boot = m_boot - 1;
        end else if (m_drain > 0) begin
            st = 1; fi = 1;
            n_drain = m_drain - 1;
            if (m_drain == 1) begin
                if (imemReady) begin go = 1; tg = TVEC; end
                else begin n_hold = 1; n_tgt = TVEC; end
            end
        end else if (m_hold) begin
            st = 1; fi = 1;
            if (TRAP_EN && trapReq) begin
                n_hold = 0; n_drain = DRAIN;
            end else if (imemReady) begin
                go = 1; tg = m_tgt; n_hold = 0;
            end
        end else if (TRAP_EN && trapReq) begin
            st = 1; fi = 1; fe = 1; n_drain = DRAIN;
        end else if (exRedirect || idRedirect) begin
            fi = 1; fe = exRedirect;
            if (imemReady) begin go = 1; tg = exRedirect ? exTarget : idTarget; end
            else begin st = 1; n_hold = 1; n_tgt = exRedirect ? exTarget : idTarget; end
        end else if (loadUseHazard) begin
            st = 1; fe = 1;
        end else if (!imemReady) begin
            st = 1; fi = 1;
        end
        e_vec = {st, go, tg, fi, fe};
    endtask

    task automatic set_idle();
        imemReady = 1; loadUseHazard = 0; idRedirect = 0; exRedirect = 0; trapReq = 0;
        idTarget = 32'h0; exTarget = 32'h0;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_boot = n_boot; m_drain = n_drain; m_hold = n_hold; m_tgt = n_tgt;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(int cycles);
        rst = 0;
        model_reset();
        repeat (cycles) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        imemReady = 1'($urandom); exRedirect = 1'($urandom); idRedirect = 1'($urandom);
        exTarget = $urandom; idTarget = $urandom;
        rst = 0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec() !== RESET_VEC) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), RESET_VEC);
        end
        @(negedge clk);
        set_idle();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_boot();
        set_idle();
        do_reset(3);
        for (int i = 0; i < BOOT + 3; i++) begin
            settle();
            n_cmp++;
            if (dut_vec() !== e_vec) begin
                n_err++;
                $display("FAIL boot_model[%0d]: got %h expected %h", i, dut_vec(), e_vec);
            end
            n_cmp++;
            if ({isStalled, flushIfId, flushIdEx} !== {3{1'(i < BOOT)}}) begin
                n_err++;
                $display("FAIL boot_stall[%0d]: got %b expected %b", i,
                         {isStalled, flushIfId, flushIdEx}, {3{1'(i < BOOT)}});
            end
            advance();
        end
    endtask

    task automatic test_ex_beats_id();
        set_idle();
        exRedirect = 1; exTarget = 32'h40; idRedirect = 1; idTarget = 32'h80;
        settle();
        n_cmp++;
        if (dut_vec() !== e_vec) begin
            n_err++;
            $display("FAIL ex_vs_id_model: got %h expected %h", dut_vec(), e_vec);
        end
        n_cmp++;
        if ({shouldGoToTarget, jumpTarget, flushIfId, flushIdEx} !== {1'b1, 32'h40, 2'b11}) begin
            n_err++;
            $display("FAIL ex_vs_id: got go=%b tgt=%h fl=%b%b expected go=1 tgt=00000040 fl=11",
                     shouldGoToTarget, jumpTarget, flushIfId, flushIdEx);
        end
        advance();
        set_idle();
        settle();
        n_cmp++;
        if (dut_vec() !== 36'h0) begin
            n_err++;
            $display("FAIL ex_vs_id_after: got %h expected %h", dut_vec(), 36'h0);
        end
        advance();
    endtask

    task automatic test_mem_wait();
        set_idle();
        imemReady = 0; idRedirect = 1; idTarget = 32'h200;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_cmp++;
            if (dut_vec() !== e_vec) begin
                n_err++;
                $display("FAIL mem_wait_model[%0d]: got %h expected %h", i, dut_vec(), e_vec);
            end
            n_cmp++;
            if ({isStalled, shouldGoToTarget} !== {1'b1, 1'(i == 3)} ||
                (i == 3 && jumpTarget !== 32'h200)) begin
                n_err++;
                $display("FAIL mem_wait[%0d]: got stall=%b go=%b tgt=%h expected stall=1 go=%b",
                         i, isStalled, shouldGoToTarget, jumpTarget, 1'(i == 3));
            end
            advance();
            set_idle();
            imemReady = (i == 2);
        end
    endtask

    task automatic test_load_use();
        set_idle();
        loadUseHazard = 1;
        settle();
        n_cmp++;
        if ({isStalled, shouldGoToTarget, flushIfId, flushIdEx} !== 4'b1001) begin
            n_err++;
            $display("FAIL load_use_alone: got %b expected 1001",
                     {isStalled, shouldGoToTarget, flushIfId, flushIdEx});
        end
        advance();
        exRedirect = 1; exTarget = {$urandom} & 32'hFFFF_FFFC;
        settle();
        n_cmp++;
        if (dut_vec() !== e_vec || isStalled !== 1'b0 || jumpTarget !== exTarget) begin
            n_err++;
            $display("FAIL load_use_redirect: got %h expected %h", dut_vec(), e_vec);
        end
        advance();
    endtask

    task automatic test_trap();
        set_idle();
        trapReq = 1;
        for (int i = 0; i <= DRAIN + 1; i++) begin
            settle();
            n_cmp++;
            if (dut_vec() !== e_vec) begin
                n_err++;
                $display("FAIL trap_model[%0d]: got %h expected %h", i, dut_vec(), e_vec);
            end
`ifdef FETCH_TRAP_REDIRECT_EN
            n_cmp++;
            if (shouldGoToTarget !== 1'(i == DRAIN) ||
                (i == DRAIN && jumpTarget !== TVEC)) begin
                n_err++;
                $display("FAIL trap_timing[%0d]: got go=%b tgt=%h expected go=%b", i,
                         shouldGoToTarget, jumpTarget, 1'(i == DRAIN));
            end
`endif
            advance();
            set_idle();
            if (i == 0) begin exRedirect = 1; exTarget = 32'h0000_0abc; end
        end
    endtask

    task automatic test_reset_in_hold();
        set_idle();
        imemReady = 0; exRedirect = 1; exTarget = 32'h300;
        settle();
        advance();
        set_idle();
        imemReady = 0;
        settle();
        n_cmp++;
        if (dut_vec() !== e_vec) begin
            n_err++;
            $display("FAIL hold_before_reset: got %h expected %h", dut_vec(), e_vec);
        end
        #2;
        rst = 0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec() !== RESET_VEC) begin
            n_err++;
            $display("FAIL hold_reset_async: got %h expected %h", dut_vec(), RESET_VEC);
        end
        repeat (2) @(negedge clk);
        rst = 1;
        imemReady = 1;
        for (int i = 0; i < BOOT + 3; i++) begin
            settle();
            n_cmp++;
            if (dut_vec() !== e_vec || shouldGoToTarget !== 1'b0) begin
                n_err++;
                $display("FAIL hold_reset_stale[%0d]: got %h expected %h", i, dut_vec(), e_vec);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                set_idle();
                do_reset(int'($urandom_range(1, 3)));
            end
            imemReady     = ($urandom_range(0, 3) != 0);
            exRedirect    = ($urandom_range(0, 4) == 0);
            idRedirect    = ($urandom_range(0, 3) == 0);
            loadUseHazard = ($urandom_range(0, 3) == 0);
            trapReq       = ($urandom_range(0, 15) == 0);
            exTarget      = $urandom;
            idTarget      = $urandom;
            settle();
            n_cmp++;
            if (dut_vec() !== e_vec) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), e_vec);
            end
            advance();
        end
    endtask

    initial begin
        set_idle();
        rst = 1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_boot();
        test_ex_beats_id();
        test_mem_wait();
        test_load_use();
        test_trap();
        test_reset_in_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the program counter of the five-stage pipeline. It merges the stall and redirect sources (instruction-memory wait, load-use hazard, ID-stage jump, EX-stage branch, optional trap) into the PC's `isStalled` / `shouldGoToTarget` / `jumpTarget` controls. It also emits the IF/ID and ID/EX flush strobes. The block sits between the hazard unit, the branch/jump resolvers and the program counter.

## Interface
- `BOOT_CYCLES`, 2: cycles the PC is held stalled after reset release (≥1).
- `DRAIN_CYCLES`, 3: cycles waited after a trap before redirecting (≥1).
- `TRAP_VECTOR`, 32'h0000_0100: trap redirect target.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imemReady`  in  1  instruction memory accepts a fetch this cycle.
- `loadUseHazard`  in  1  ID instruction depends on the load in EX.
- `idRedirect`  in  1  jump resolved in ID.
- `idTarget`  in  32  target for `idRedirect`.
- `exRedirect`  in  1  taken branch resolved in EX.
- `exTarget`  in  32  target for `exRedirect`.
- `trapReq`  in  1  exception raised by the EX instruction (only with the macro).
- `isStalled`  out  1  PC hold.
- `shouldGoToTarget`  out  1  PC loads `jumpTarget` at the next edge, regardless of `isStalled`.
- `jumpTarget`  out  32  redirect address; 0 when `shouldGoToTarget` = 0.
- `flushIfId`  out  1  bubble the IF/ID register.
- `flushIdEx`  out  1  bubble the ID/EX register.

## Operation
- **States:** BOOT, RUN, HOLD, DRAIN (DRAIN exists only with the macro).
- **Registers:**
  - 32-bit `pendingTarget`.
  - One down-counter, wide enough for max(`BOOT_CYCLES`, `DRAIN_CYCLES`).
- **BOOT:**
  - Outputs: `isStalled`=1, `flushIfId`=1, `flushIdEx`=1, `shouldGoToTarget`=0.
  - Counter loads `BOOT_CYCLES`-1 on reset and moves to RUN when it reaches 0.
  - All inputs are ignored.
- **RUN**, priority trap > EX > ID > load-use > memory wait:
  - **`trapReq`:** go to DRAIN, counter = `DRAIN_CYCLES`-1. Outputs: `isStalled`=1, both flushes=1.
  - **`exRedirect`, `imemReady`=1:**
    - `shouldGoToTarget`=1, `jumpTarget`=`exTarget`, both flushes=1.
    - `idRedirect` and `loadUseHazard` are ignored.
  - **`idRedirect`, `imemReady`=1:**
    - `shouldGoToTarget`=1, `jumpTarget`=`idTarget`, `flushIfId`=1.
    - `loadUseHazard` is ignored.
  - **Any redirect with `imemReady`=0:**
    - Winning target latched into `pendingTarget`; go to HOLD.
    - Outputs: `isStalled`=1, `shouldGoToTarget`=0, flushes as for that redirect.
  - **`loadUseHazard` alone:** `isStalled`=1, `flushIdEx`=1.
  - **`imemReady`=0 alone:** `isStalled`=1, `flushIfId`=1.
- **HOLD:**
  - Outputs: `isStalled`=1, `flushIfId`=1.
  - Redirect and hazard inputs are ignored.
  - When `imemReady`=1: `shouldGoToTarget`=1, `jumpTarget`=`pendingTarget`, then RUN.
  - `trapReq` in HOLD: discard the pending target and go to DRAIN (overrides `imemReady`).
- **DRAIN:**
  - Outputs: `isStalled`=1, `flushIfId`=1; all other inputs are ignored.
  - At counter 0 with `imemReady`=1: `shouldGoToTarget`=1, `jumpTarget`=`TRAP_VECTOR`, then RUN.
  - At counter 0 with `imemReady`=0: latch `TRAP_VECTOR` into `pendingTarget`, then HOLD.
- **Output timing:** outputs are combinational from state, counter and inputs. No output is ever X.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - State = BOOT, counter = `BOOT_CYCLES`-1, `pendingTarget`=0.
  - Outputs: `isStalled`=1, `shouldGoToTarget`=0, `jumpTarget`=0, `flushIfId`=1, `flushIdEx`=1.
  - Mid-operation reset discards any pending redirect or drain.
- **Boot release:** first RUN cycle is the `BOOT_CYCLES`-th rising edge after `rst` goes high.
- **Redirect in RUN:** zero-cycle decision; the PC takes the target at the same edge.
- **Redirect from HOLD:** taken at the first edge where `imemReady`=1.
- **Trap:** redirect to `TRAP_VECTOR` occurs on the `DRAIN_CYCLES`-th cycle after `trapReq`, assuming `imemReady`=1.
- **Simultaneous `exRedirect` + `idRedirect`:** EX wins; the ID target is lost.

## Configuration
- **`FETCH_TRAP_REDIRECT_EN` defined:**
  - `trapReq`, `DRAIN_CYCLES`, `TRAP_VECTOR` and the DRAIN state are present as described.
- **Not defined:**
  - `trapReq` port is still present but ignored.
  - DRAIN state is not synthesised.
  - Behaviour is otherwise identical.

## Test plan
- **Boot:**
  - Stimulus: reset low for 3 cycles, release, `imemReady`=1.
  - Response: `isStalled`=1 for exactly 2 cycles, then 0; flushes drop with it.
- **EX beats ID:**
  - Stimulus: in RUN, `exRedirect`=1 with `exTarget`=0x40, and `idRedirect`=1 with `idTarget`=0x80, same cycle.
  - Response: `shouldGoToTarget`=1, `jumpTarget`=0x40, both flushes=1.
- **Memory wait:**
  - Stimulus: `idRedirect`=1 with `idTarget`=0x200 while `imemReady`=0, then `imemReady` stays 0 for 2 cycles and rises.
  - Response: `jumpTarget`=0x200 with `shouldGoToTarget`=1 only in the `imemReady`=1 cycle; `isStalled`=1 throughout.
- **Load-use:**
  - Stimulus: `loadUseHazard`=1 alone.
  - Response: `isStalled`=1, `flushIdEx`=1, `flushIfId`=0.
  - Stimulus: `loadUseHazard`=1 with `exRedirect`=1.
  - Response: redirect only.
- **Trap (macro on):**
  - Stimulus: `trapReq`=1 pulse.
  - Response: redirect to 0x100 on cycle 3; an `exRedirect` during the drain has no effect.
- **Reset in HOLD:**
  - Stimulus: assert `rst`=0 asynchronously while in HOLD.
  - Response: outputs reach their reset values immediately; after release, no stale `pendingTarget` redirect is issued.
